// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller and its step timer.
// Contents:
//   DUTY_W_DEFAULT   default width of duty/cutoff values
//   PERIOD_W_DEFAULT default width of the step-period field
//   fade_state_t     controller state encoding
package pwm_pkg;

  localparam int unsigned DUTY_W_DEFAULT   = 8;
  localparam int unsigned PERIOD_W_DEFAULT = 16;

  typedef enum logic {
    IDLE,
    RAMP
  } fade_state_t;

endpackage

// File: rtl/pwm_step_timer.sv
// Step timer for the fade controller: a down-counter that is loaded with a period,
// counts while enabled and raises a one-cycle expire pulse every 'period' enabled cycles.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   load          load load_value as both the current count and the reload period
//   load_value    period in clocks; must be non-zero
//   enable        count this cycle
//   expire        high for the enabled cycle in which the period elapses
module pwm_step_timer
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_value,
  input  logic                enable,
  output logic                expire
);

  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] period_q, period_d;

  // A count of 1 is the last cycle of the period; the step happens on the next edge.
  assign expire = enable && (count_q == PERIOD_W'(1));

  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    if (load) begin
      count_d  = load_value;
      period_d = load_value;
    end else if (enable) begin
      count_d = expire ? period_q : count_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      period_q <= '0;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/pwm_fade_controller.sv
// Fade command stage for pwm_driver: accepts a (target, step, period) command and ramps the
// duty toward the target, emitting a one-cycle set_cutoff_en pulse with each new value.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   cmd_valid      command present; accepted when cmd_ready and no abort
//   cmd_ready      high in IDLE
//   cmd_target     final duty value
//   cmd_step       duty increment per step (0 acts as 1)
//   cmd_period     clocks per step (0 acts as 1)
//   abort          stop the ramp, keep the current duty
//   set_cutoff_en  one-cycle load strobe for pwm_driver
//   cutoff_value   current duty (mirror of the internal cur register)
//   busy           ramp in progress
//   done           one-cycle pulse when the target is reached
module pwm_fade_controller
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W   = DUTY_W_DEFAULT,
  parameter int unsigned PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DUTY_W-1:0]   cmd_target,
  input  logic [DUTY_W-1:0]   cmd_step,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                set_cutoff_en,
  output logic [DUTY_W-1:0]   cutoff_value,
  output logic                busy,
  output logic                done
);

  fade_state_t state_q, state_d;
  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] step_q, step_d;
  logic              set_en_q, set_en_d;
  logic              done_q, done_d;

  logic [DUTY_W-1:0]   eff_step;
  logic [PERIOD_W-1:0] eff_period;
  logic                accept;
  logic                timer_load, timer_en, timer_expire;

  logic              up;
  logic [DUTY_W:0]   diff, delta;
  logic [DUTY_W-1:0] next_cur;
  logic              unused_delta_msb;

  assign eff_step   = (cmd_step == '0) ? DUTY_W'(1) : cmd_step;
  assign eff_period = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
  assign accept     = (state_q == IDLE) && cmd_valid && !abort;

  // Distance is computed one bit wider so it never wraps; delta is clamped to it so the
  // ramp lands exactly on the target instead of overshooting.
  assign up       = (target_q > cur_q);
  assign diff     = up ? ({1'b0, target_q} - {1'b0, cur_q}) : ({1'b0, cur_q} - {1'b0, target_q});
  assign delta    = ({1'b0, step_q} < diff) ? {1'b0, step_q} : diff;
  assign next_cur = up ? (cur_q + delta[DUTY_W-1:0]) : (cur_q - delta[DUTY_W-1:0]);
  // delta never exceeds the full-scale range, so its top bit is always zero.
  assign unused_delta_msb = delta[DUTY_W];

  pwm_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_step_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (eff_period),
    .enable     (timer_en),
    .expire     (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    target_d   = target_q;
    step_d     = step_q;
    set_en_d   = 1'b0;
    done_d     = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d   = cmd_target;
          step_d     = eff_step;
          timer_load = 1'b1;
          if (cmd_target == cur_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        timer_en = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (cur_q == target_q) begin
          // Final step already issued last cycle; drop back to IDLE one cycle after done.
          state_d = IDLE;
        end else if (timer_expire) begin
          cur_d    = next_cur;
          set_en_d = 1'b1;
          done_d   = (next_cur == target_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      set_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      step_q   <= step_d;
      set_en_q <= set_en_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q == RAMP);
  assign cutoff_value  = cur_q;
  assign set_cutoff_en = set_en_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Self-checking bench for pwm_fade_controller. A per-edge expectation table is filled from
// each command's ramp schedule and compared against the DUT every cycle; literal checks on
// the recorded pulse trains pin the schedule itself.
module tb_pwm_fade_controller;

  localparam int DW = 8;
  localparam int PW = 16;
  localparam int NE = 4096;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_target = '0;
  logic [DW-1:0] cmd_step = '0;
  logic [PW-1:0] cmd_period = '0;
  logic          abort = 1'b0;
  logic          set_cutoff_en;
  logic [DW-1:0] cutoff_value;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pwm_fade_controller #(
    .DUTY_W   (DW),
    .PERIOD_W (PW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_target    (cmd_target),
    .cmd_step      (cmd_step),
    .cmd_period    (cmd_period),
    .abort         (abort),
    .set_cutoff_en (set_cutoff_en),
    .cutoff_value  (cutoff_value),
    .busy          (busy),
    .done          (done)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int tests = 0;
  int fails = 0;

  // Expected outputs visible just after edge e, valid for plan_start <= e < plan_end;
  // outside that window the controller is idle holding m_cur.
  int e_busy[NE];
  int e_pulse[NE];
  int e_done[NE];
  int e_val[NE];
  int plan_start = 0;
  int plan_end = 0;
  int m_cur = 0;
  bit chk_en = 1'b0;

  int p_edge[$];
  int p_val[$];
  int p_done[$];
  int done_alone = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act,
               exp, exp);
    end
  endtask

  // Ramp schedule: one step every P edges after acceptance, each moving by min(S, distance).
  task automatic plan_cmd(input int n, input int tgt, input int stp, input int per);
    int p, s, v, d, e, pulse;
    plan_start = n;
    if (tgt == m_cur) begin
      e_busy[n] = 0; e_pulse[n] = 0; e_done[n] = 1; e_val[n] = m_cur;
      plan_end = n + 1;
    end else begin
      p = (per == 0) ? 1 : per;
      s = (stp == 0) ? 1 : stp;
      v = m_cur;
      e = n;
      while (e < NE - 1) begin
        pulse = 0;
        if (e > n && ((e - n) % p) == 0) begin
          d = (tgt > v) ? tgt - v : v - tgt;
          if (s < d) d = s;
          v = (tgt > v) ? v + d : v - d;
          pulse = 1;
        end
        e_busy[e] = 1; e_pulse[e] = pulse; e_val[e] = v;
        e_done[e] = (pulse == 1 && v == tgt) ? 1 : 0;
        if (pulse == 1 && v == tgt) break;
        e++;
      end
      plan_end = e + 1;
      m_cur = tgt;
    end
  endtask

  always @(negedge clk) begin : cmp
    int e, eb, ep, ed, ev, exp_v, act_v;
    if (chk_en) begin
      e = edge_cnt;
      if (e >= plan_start && e < plan_end && e < NE) begin
        eb = e_busy[e]; ep = e_pulse[e]; ed = e_done[e]; ev = e_val[e];
      end else begin
        eb = 0; ep = 0; ed = 0; ev = m_cur;
      end
      exp_v = (eb << 11) | ((1 - eb) << 10) | (ep << 9) | (ed << 8) | (ev & 255);
      act_v = int'({busy, cmd_ready, set_cutoff_en, done, cutoff_value});
      check($sformatf("cycle_e%0d {busy,ready,set,done,val}", e), act_v, exp_v);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (set_cutoff_en) begin
        p_edge.push_back(edge_cnt);
        p_val.push_back(int'(cutoff_value));
        p_done.push_back(int'(done));
      end else if (done) begin
        done_alone++;
      end
    end
  end

  task automatic clear_log();
    p_edge.delete(); p_val.delete(); p_done.delete();
  endtask

  task automatic send(input int t, input int s, input int p, output int n);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_target = DW'(t); cmd_step = DW'(s); cmd_period = PW'(p);
    @(posedge clk); #1;
    n = edge_cnt;
    cmd_valid = 1'b0;
    plan_cmd(n, t, s, p);
  endtask

  initial begin
    int n, a, da;
    #2;
    check("reset_cutoff", int'(cutoff_value), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_set_en", int'(set_cutoff_en), 0);
    check("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // 1: slow unit-step ramp 0 -> 8
    clear_log();
    send(8, 1, 4, n);
    repeat (40) @(posedge clk);
    check("t1_pulse_count", p_edge.size(), 8);
    if (p_edge.size() == 8) begin
      check("t1_first_edge", p_edge[0] - n, 4);
      check("t1_first_val", p_val[0], 1);
      check("t1_spacing", p_edge[7] - p_edge[6], 4);
      check("t1_last_val", p_val[7], 8);
      check("t1_last_done", p_done[7], 1);
    end

    // Jump to 250 with an oversized step: clamps to a single exact step.
    clear_log();
    send(250, 255, 1, n);
    repeat (5) @(posedge clk);
    check("clamp_pulse_count", p_edge.size(), 1);
    check("clamp_cutoff", int'(cutoff_value), 250);

    // 2: 250 -> 254 with step 16
    clear_log();
    send(254, 16, 2, n);
    repeat (6) @(posedge clk);
    check("t2_pulse_count", p_edge.size(), 1);
    if (p_edge.size() == 1) begin
      check("t2_edge", p_edge[0] - n, 2);
      check("t2_val", p_val[0], 254);
      check("t2_done", p_done[0], 1);
    end

    // 3: 254 -> 0, step 100, period 0
    clear_log();
    send(0, 100, 0, n);
    repeat (6) @(posedge clk);
    check("t3_pulse_count", p_edge.size(), 3);
    if (p_edge.size() == 3) begin
      check("t3_v0", p_val[0], 154);
      check("t3_v1", p_val[1], 54);
      check("t3_v2", p_val[2], 0);
      check("t3_first_edge", p_edge[0] - n, 1);
      check("t3_last_edge", p_edge[2] - n, 3);
      check("t3_done", p_done[2], 1);
    end

    // 4: target equals current duty
    clear_log();
    da = done_alone;
    send(0, 5, 3, n);
    repeat (4) @(posedge clk);
    check("t4_pulse_count", p_edge.size(), 0);
    check("t4_done_alone", done_alone - da, 1);

    // 5: abort coincident with the third expiry
    clear_log();
    send(128, 1, 8, n);
    repeat (23) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    a = edge_cnt;
    abort = 1'b0;
    plan_end = a;
    m_cur = e_val[a - 1];
    repeat (5) @(posedge clk);
    check("t5_pulse_count", p_edge.size(), 2);
    if (p_edge.size() == 2) begin
      check("t5_v0", p_val[0], 1);
      check("t5_v1", p_val[1], 2);
      check("t5_no_done", p_done[0] + p_done[1], 0);
    end
    check("t5_cutoff", int'(cutoff_value), 2);

    clear_log();
    send(4, 0, 2, n);
    repeat (8) @(posedge clk);
    check("t5b_pulse_count", p_edge.size(), 2);
    if (p_edge.size() == 2) begin
      check("t5b_v0", p_val[0], 3);
      check("t5b_v1", p_val[1], 4);
      check("t5b_edge", p_edge[1] - n, 4);
    end

    // Abort in IDLE blocks a simultaneous command.
    clear_log();
    @(posedge clk); #1;
    abort = 1'b1; cmd_valid = 1'b1; cmd_target = DW'(9); cmd_step = DW'(1); cmd_period = PW'(1);
    @(posedge clk); #1;
    abort = 1'b0; cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    check("idle_abort_pulses", p_edge.size(), 0);
    check("idle_abort_cutoff", int'(cutoff_value), 4);

    // 6: asynchronous reset mid-ramp
    clear_log();
    send(200, 1, 3, n);
    repeat (10) @(posedge clk);
    #2;
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_cutoff", int'(cutoff_value), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_set_en", int'(set_cutoff_en), 0);
    check("t6_ready", int'(cmd_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    plan_start = 0;
    plan_end = 0;
    m_cur = 0;
    clear_log();
    chk_en = 1'b1;
    repeat (20) @(posedge clk);
    check("t6_no_pulses", p_edge.size(), 0);
    check("t6_cutoff_after", int'(cutoff_value), 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
